// File: rtl/rename_map_table_if.sv
// Rename-stage bus: instruction queue group in, free-list slots, renamed group out,
// commit mappings and recovery controls. master = surrounding pipeline, slave = map table.
interface rename_map_table_if #(
    parameter int unsigned W             = 2,
    parameter int unsigned NUM_ARCH_REGS = 32,
    parameter int unsigned NUM_PHYS_REGS = 128,
    parameter int unsigned NUM_CKPT      = 4
);
    localparam int unsigned PW = $clog2(NUM_PHYS_REGS);
    localparam int unsigned AW = $clog2(NUM_ARCH_REGS + 1);
    localparam int unsigned CW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_lane_valid;
    logic [W-1:0]      in_dst_we;
    logic [W*AW-1:0]   in_dst_arch;
    logic [W*AW-1:0]   in_src1_arch;
    logic [W*AW-1:0]   in_src2_arch;
    logic [W-1:0]      in_sets_flags;
    logic [W-1:0]      in_uses_flags;
    logic [W-1:0]      in_is_branch;

    logic [2*W-1:0]    frl_avail;
    logic [2*W*PW-1:0] frl_data;
    logic [2*W-1:0]    frl_pop;

    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_lane_valid;
    logic [W*PW-1:0]   out_src1_phys;
    logic [W*PW-1:0]   out_src2_phys;
    logic [W*PW-1:0]   out_flags_phys;
    logic [W*PW-1:0]   out_dst_phys;
    logic [W*PW-1:0]   out_dst_old_phys;
    logic [W*PW-1:0]   out_flag_dst_phys;
    logic [W*PW-1:0]   out_flag_old_phys;
    logic [W*CW-1:0]   out_ckpt_id;

    logic [W-1:0]      cm_valid;
    logic [W*AW-1:0]   cm_arch;
    logic [W*PW-1:0]   cm_phys;

    logic              flush_in;
    logic              recover_in;
    logic [CW-1:0]     recover_id;
    logic              ckpt_release_in;

    modport master (
        output in_valid, in_lane_valid, in_dst_we, in_dst_arch, in_src1_arch, in_src2_arch,
               in_sets_flags, in_uses_flags, in_is_branch, frl_avail, frl_data, out_ready,
               cm_valid, cm_arch, cm_phys, flush_in, recover_in, recover_id, ckpt_release_in,
        input  in_ready, frl_pop, out_valid, out_lane_valid, out_src1_phys, out_src2_phys,
               out_flags_phys, out_dst_phys, out_dst_old_phys, out_flag_dst_phys,
               out_flag_old_phys, out_ckpt_id
    );

    modport slave (
        input  in_valid, in_lane_valid, in_dst_we, in_dst_arch, in_src1_arch, in_src2_arch,
               in_sets_flags, in_uses_flags, in_is_branch, frl_avail, frl_data, out_ready,
               cm_valid, cm_arch, cm_phys, flush_in, recover_in, recover_id, ckpt_release_in,
        output in_ready, frl_pop, out_valid, out_lane_valid, out_src1_phys, out_src2_phys,
               out_flags_phys, out_dst_phys, out_dst_old_phys, out_flag_dst_phys,
               out_flag_old_phys, out_ckpt_id
    );
endinterface

// File: rtl/rename_map_table.sv
// rename_map_table: W-lane register alias table with intra-group bypass, committed map
// for flush recovery and a registered valid/ready output stage toward the ROB.
// Define RENAME_CKPT_EN to add NUM_CKPT branch checkpoints for mispredict recovery.
module rename_map_table #(
    parameter int unsigned W             = 2,
    parameter int unsigned NUM_ARCH_REGS = 32,
    parameter int unsigned NUM_PHYS_REGS = 128,
    parameter int unsigned ZERO_REG      = 31,
    parameter int unsigned NUM_CKPT      = 4
) (
    input  logic              clk,
    input  logic              rst_in,
    rename_map_table_if.slave bus
);
    localparam int unsigned PW   = $clog2(NUM_PHYS_REGS);
    localparam int unsigned AW   = $clog2(NUM_ARCH_REGS + 1);
    localparam int unsigned CW   = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;
    localparam int unsigned NMAP = NUM_ARCH_REGS + 1;
    localparam int unsigned NZCV = NUM_ARCH_REGS;

    function automatic logic [AW-1:0] arch_at(input logic [W*AW-1:0] v, input int i);
        return v[i*AW +: AW];
    endfunction

    logic [PW-1:0]   r_spec [NMAP];
    logic [PW-1:0]   r_cmt  [NMAP];
    logic [PW-1:0]   w_map  [NMAP];
    logic [PW-1:0]   w_cmt_next [NMAP];

    logic            r_out_valid;
    logic [W-1:0]    r_out_lane_valid;
    logic [W*PW-1:0] r_src1, r_src2, r_flg, r_dst, r_old, r_fdst, r_fold;
    logic [W*CW-1:0] r_ckpt_id;

    logic [W*PW-1:0] w_src1, w_src2, w_flg, w_dst, w_old, w_fdst, w_fold;
    logic [W*CW-1:0] w_ckpt_id;
    logic [W-1:0]    w_need_dst, w_need_flg;
    logic            w_frl_ok, w_fire, w_ready, w_recover, w_ckpt_ok;

`ifdef RENAME_CKPT_EN
    logic [PW-1:0]   r_ckpt [NUM_CKPT][NMAP];
    logic [PW-1:0]   w_snap [NMAP];
    logic [CW-1:0]   r_head, r_tail;
    logic [CW:0]     r_count;
    logic            w_branch, w_alloc, w_rel;

    assign w_branch  = |(bus.in_lane_valid & bus.in_is_branch);
    assign w_ckpt_ok = !w_branch || (r_count < (CW+1)'(NUM_CKPT));
    assign w_recover = bus.recover_in;
    assign w_alloc   = w_fire & w_branch;
    assign w_rel     = bus.ckpt_release_in & (r_count != '0);
`else
    logic w_unused;
    assign w_unused  = ^{bus.in_is_branch, bus.recover_in, bus.recover_id, bus.ckpt_release_in};
    assign w_ckpt_ok = 1'b1;
    assign w_recover = 1'b0;
`endif

    // Free-list slots each lane needs: dst for real GPR writes, NZCV for flag setters
    always_comb begin
        w_need_dst = '0;
        w_need_flg = '0;
        for (int i = 0; i < int'(W); i++) begin
            w_need_dst[i] = bus.in_lane_valid[i] & bus.in_dst_we[i] &
                            (arch_at(bus.in_dst_arch, i) != AW'(ZERO_REG));
            w_need_flg[i] = bus.in_lane_valid[i] & bus.in_sets_flags[i];
        end
    end

    assign w_frl_ok     = &(~{w_need_flg, w_need_dst} | bus.frl_avail);
    assign w_ready      = (!r_out_valid || bus.out_ready) && !bus.flush_in && !w_recover &&
                          w_frl_ok && w_ckpt_ok;
    assign w_fire       = bus.in_valid & w_ready;
    assign bus.in_ready = w_ready;
    assign bus.frl_pop  = w_fire ? {w_need_flg, w_need_dst} : '0;

    // Walk lanes in program order over a running copy of the map, so each lane sees
    // earlier lanes' writes and the final copy is the post-group speculative map
    always_comb begin
        w_map     = r_spec;
        w_src1    = '0;
        w_src2    = '0;
        w_flg     = '0;
        w_dst     = '0;
        w_old     = '0;
        w_fdst    = '0;
        w_fold    = '0;
        w_ckpt_id = '0;
`ifdef RENAME_CKPT_EN
        w_snap    = r_spec;
`endif
        for (int i = 0; i < int'(W); i++) begin
            if (bus.in_lane_valid[i]) begin
                if (arch_at(bus.in_src1_arch, i) != AW'(ZERO_REG))
                    w_src1[i*PW +: PW] = w_map[arch_at(bus.in_src1_arch, i)];
                if (arch_at(bus.in_src2_arch, i) != AW'(ZERO_REG))
                    w_src2[i*PW +: PW] = w_map[arch_at(bus.in_src2_arch, i)];
                if (bus.in_uses_flags[i])
                    w_flg[i*PW +: PW] = w_map[NZCV];
                if (w_need_dst[i]) begin
                    w_dst[i*PW +: PW] = bus.frl_data[i*PW +: PW];
                    w_old[i*PW +: PW] = w_map[arch_at(bus.in_dst_arch, i)];
                    w_map[arch_at(bus.in_dst_arch, i)] = bus.frl_data[i*PW +: PW];
                end
                if (w_need_flg[i]) begin
                    w_fdst[i*PW +: PW] = bus.frl_data[(W+i)*PW +: PW];
                    w_fold[i*PW +: PW] = w_map[NZCV];
                    w_map[NZCV]        = bus.frl_data[(W+i)*PW +: PW];
                end
`ifdef RENAME_CKPT_EN
                if (bus.in_is_branch[i]) begin
                    w_snap                 = w_map;
                    w_ckpt_id[i*CW +: CW]  = r_tail;
                end
`endif
            end
        end
    end

    // Retired mappings applied in lane order; later lanes override earlier ones
    always_comb begin
        w_cmt_next = r_cmt;
        for (int i = 0; i < int'(W); i++) begin
            if (bus.cm_valid[i])
                w_cmt_next[arch_at(bus.cm_arch, i)] = bus.cm_phys[i*PW +: PW];
        end
    end

    // Speculative and committed maps; flush beats recover beats fire
    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int a = 0; a < int'(NMAP); a++) begin
                r_spec[a] <= PW'(a);
                r_cmt[a]  <= PW'(a);
            end
        end else begin
            r_cmt <= w_cmt_next;
            if (bus.flush_in)
                r_spec <= w_cmt_next;
`ifdef RENAME_CKPT_EN
            else if (bus.recover_in)
                r_spec <= r_ckpt[bus.recover_id];
`endif
            else if (w_fire)
                r_spec <= w_map;
        end
    end

    // Output stage: load on accept, hold while stalled, drop on flush/recover
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_out_valid      <= 1'b0;
            r_out_lane_valid <= '0;
            r_src1           <= '0;
            r_src2           <= '0;
            r_flg            <= '0;
            r_dst            <= '0;
            r_old            <= '0;
            r_fdst           <= '0;
            r_fold           <= '0;
            r_ckpt_id        <= '0;
        end else begin
            if (bus.flush_in || w_recover)
                r_out_valid <= 1'b0;
            else if (w_fire)
                r_out_valid <= 1'b1;
            else if (bus.out_ready)
                r_out_valid <= 1'b0;
            if (w_fire) begin
                r_out_lane_valid <= bus.in_lane_valid;
                r_src1           <= w_src1;
                r_src2           <= w_src2;
                r_flg            <= w_flg;
                r_dst            <= w_dst;
                r_old            <= w_old;
                r_fdst           <= w_fdst;
                r_fold           <= w_fold;
                r_ckpt_id        <= w_ckpt_id;
            end
        end
    end

`ifdef RENAME_CKPT_EN
    // Snapshot storage, written at the tail when a branch group is accepted
    always_ff @(posedge clk) begin
        if (w_alloc)
            r_ckpt[r_tail] <= w_snap;
    end

    // Circular checkpoint pointers
    always_ff @(posedge clk) begin
        if (rst_in || bus.flush_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.recover_in) begin
            r_tail  <= bus.recover_id + CW'(1);
            r_count <= (CW+1)'(CW'(bus.recover_id - r_head)) + (CW+1)'(1);
        end else begin
            if (w_alloc)
                r_tail <= r_tail + CW'(1);
            if (w_rel)
                r_head <= r_head + CW'(1);
            r_count <= r_count + (CW+1)'(w_alloc) - (CW+1)'(w_rel);
        end
    end

    // At most one branch per group can own a checkpoint
    a_one_branch: assert property (@(posedge clk) disable iff (rst_in)
        bus.in_valid |-> ($countones(bus.in_lane_valid & bus.in_is_branch) <= 1));
`endif

    assign bus.out_valid         = r_out_valid;
    assign bus.out_lane_valid    = r_out_lane_valid;
    assign bus.out_src1_phys     = r_src1;
    assign bus.out_src2_phys     = r_src2;
    assign bus.out_flags_phys    = r_flg;
    assign bus.out_dst_phys      = r_dst;
    assign bus.out_dst_old_phys  = r_old;
    assign bus.out_flag_dst_phys = r_fdst;
    assign bus.out_flag_old_phys = r_fold;
    assign bus.out_ckpt_id       = r_ckpt_id;
endmodule

// File: tb/tb_rename_map_table.sv
// Bench for rename_map_table (default build): directed scenarios then random groups,
// predicted by an arch-level map model and checked through a scoreboard queue.
module tb_rename_map_table;
    localparam int unsigned W  = 2;
    localparam int unsigned NA = 32;
    localparam int unsigned NP = 128;
    localparam int unsigned ZR = 31;
    localparam int unsigned NC = 4;
    localparam int unsigned PW = 7;
    localparam int unsigned AW = 6;
    localparam int          NZ = 32;

    logic clk = 1'b0;
    logic rst_in;
    always #5 clk = ~clk;

    rename_map_table_if #(.W(W), .NUM_ARCH_REGS(NA), .NUM_PHYS_REGS(NP), .NUM_CKPT(NC)) bus ();

    rename_map_table #(.W(W), .NUM_ARCH_REGS(NA), .NUM_PHYS_REGS(NP), .ZERO_REG(ZR),
                       .NUM_CKPT(NC)) dut (.clk(clk), .rst_in(rst_in), .bus(bus));

    typedef struct packed {
        logic [W-1:0]    lv;
        logic [W*PW-1:0] s1, s2, fl, d, o, fd, fo;
    } grp_t;

    grp_t q[$];
    int   spec_m [NA+1];
    int   cmt_m  [NA+1];
    logic m_valid;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int a_dst(input int i); return int'(bus.in_dst_arch[i*AW +: AW]); endfunction
    function automatic int a_s1(input int i);  return int'(bus.in_src1_arch[i*AW +: AW]); endfunction
    function automatic int a_s2(input int i);  return int'(bus.in_src2_arch[i*AW +: AW]); endfunction
    function automatic int frl(input int s);   return int'(bus.frl_data[s*PW +: PW]); endfunction
    function automatic bit wr_dst(input int k);
        return bus.in_lane_valid[k] && bus.in_dst_we[k] && a_dst(k) != int'(ZR);
    endfunction
    function automatic bit wr_flg(input int k);
        return bus.in_lane_valid[k] && bus.in_sets_flags[k];
    endfunction

    // Value of a GPR as seen by lane j: youngest earlier writer in the group, else the map
    function automatic int see_gpr(input int arch, input int j);
        if (arch == int'(ZR)) return 0;
        for (int k = j - 1; k >= 0; k--)
            if (wr_dst(k) && a_dst(k) == arch) return frl(k);
        return spec_m[arch];
    endfunction

    function automatic int see_flg(input int j);
        for (int k = j - 1; k >= 0; k--)
            if (wr_flg(k)) return frl(int'(W) + k);
        return spec_m[NZ];
    endfunction

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        for (int a = 0; a <= int'(NA); a++) begin
            spec_m[a] = a;
            cmt_m[a]  = a;
        end
    endtask

    task automatic clear_inputs();
        bus.in_valid = 1'b0;  bus.in_lane_valid = '0; bus.in_dst_we = '0;
        bus.in_dst_arch = '0; bus.in_src1_arch = '0;  bus.in_src2_arch = '0;
        bus.in_sets_flags = '0; bus.in_uses_flags = '0; bus.in_is_branch = '0;
        bus.frl_avail = '1;   bus.frl_data = '0;      bus.out_ready = 1'b1;
        bus.cm_valid = '0;    bus.cm_arch = '0;       bus.cm_phys = '0;
        bus.flush_in = 1'b0;  bus.recover_in = 1'b0;  bus.recover_id = '0;
        bus.ckpt_release_in = 1'b0;
    endtask

    task automatic set_lane(input int i, input bit we, input int d, input int s1, input int s2,
                            input bit sf, input bit uf);
        bus.in_valid              = 1'b1;
        bus.in_lane_valid[i]      = 1'b1;
        bus.in_dst_we[i]          = we;
        bus.in_dst_arch[i*AW +: AW]  = AW'(d);
        bus.in_src1_arch[i*AW +: AW] = AW'(s1);
        bus.in_src2_arch[i*AW +: AW] = AW'(s2);
        bus.in_sets_flags[i]      = sf;
        bus.in_uses_flags[i]      = uf;
    endtask

    task automatic set_frl(input int s, input int v);
        bus.frl_data[s*PW +: PW] = PW'(v);
    endtask

    task automatic nxt();
        @(negedge clk);
        clear_inputs();
    endtask

    function automatic int pick_arch();
        return ($urandom_range(0, 7) == 0) ? int'(ZR) : int'($urandom_range(0, 7));
    endfunction

    task automatic rand_stim();
        bus.in_valid = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < int'(W); i++) begin
            bus.in_lane_valid[i] = ($urandom_range(0, 4) != 0);
            bus.in_dst_we[i]     = ($urandom_range(0, 3) != 0);
            bus.in_sets_flags[i] = ($urandom_range(0, 2) == 0);
            bus.in_uses_flags[i] = ($urandom_range(0, 1) == 0);
            bus.in_dst_arch[i*AW +: AW]  = AW'(pick_arch());
            bus.in_src1_arch[i*AW +: AW] = AW'(pick_arch());
            bus.in_src2_arch[i*AW +: AW] = AW'(pick_arch());
            bus.cm_valid[i]              = ($urandom_range(0, 2) == 0);
            bus.cm_arch[i*AW +: AW]      = AW'($urandom_range(0, NA));
            bus.cm_phys[i*PW +: PW]      = PW'($urandom);
        end
        bus.in_is_branch = '0;
        for (int s = 0; s < 2 * int'(W); s++) begin
            bus.frl_avail[s] = ($urandom_range(0, 7) != 0);
            set_frl(s, int'($urandom_range(1, NP - 1)));
        end
        bus.out_ready       = ($urandom_range(0, 3) != 0);
        bus.flush_in        = ($urandom_range(0, 19) == 0);
        bus.recover_in      = ($urandom_range(0, 7) == 0);
        bus.recover_id      = 2'($urandom_range(0, NC - 1));
        bus.ckpt_release_in = ($urandom_range(0, 7) == 0);
    endtask

    // Predict handshake for this cycle, enqueue the expected group, advance the model
    task automatic step();
        logic [2*W-1:0] need;
        logic           exp_rdy, fire;
        grp_t           e;
        #1;
        need = '0;
        for (int i = 0; i < int'(W); i++) begin
            need[i]     = wr_dst(i);
            need[W + i] = wr_flg(i);
        end
        exp_rdy = (!m_valid || bus.out_ready) && !bus.flush_in && ((need & ~bus.frl_avail) == '0);
        fire    = bus.in_valid && exp_rdy;
        chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        chk("frl_pop", 64'(bus.frl_pop), fire ? 64'(need) : 64'(0));
        chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
        if (fire) begin
            e    = '0;
            e.lv = bus.in_lane_valid;
            for (int j = 0; j < int'(W); j++) begin
                if (bus.in_lane_valid[j]) begin
                    e.s1[j*PW +: PW] = PW'(see_gpr(a_s1(j), j));
                    e.s2[j*PW +: PW] = PW'(see_gpr(a_s2(j), j));
                    if (bus.in_uses_flags[j]) e.fl[j*PW +: PW] = PW'(see_flg(j));
                    if (wr_dst(j)) begin
                        e.d[j*PW +: PW] = PW'(frl(j));
                        e.o[j*PW +: PW] = PW'(see_gpr(a_dst(j), j));
                    end
                    if (wr_flg(j)) begin
                        e.fd[j*PW +: PW] = PW'(frl(int'(W) + j));
                        e.fo[j*PW +: PW] = PW'(see_flg(j));
                    end
                end
            end
            q.push_back(e);
            for (int j = 0; j < int'(W); j++) begin
                if (wr_dst(j)) spec_m[a_dst(j)] = frl(j);
                if (wr_flg(j)) spec_m[NZ] = frl(int'(W) + j);
            end
        end
        for (int i = 0; i < int'(W); i++)
            if (bus.cm_valid[i]) cmt_m[int'(bus.cm_arch[i*AW +: AW])] = int'(bus.cm_phys[i*PW +: PW]);
        if (bus.flush_in) spec_m = cmt_m;
        m_valid = bus.flush_in ? 1'b0 : (fire ? 1'b1 : (m_valid && !bus.out_ready));
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_in = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_lane_valid", 64'(bus.out_lane_valid), 64'(0));
        chk("rst_src1", 64'(bus.out_src1_phys), 64'(0));
        chk("rst_dst", 64'(bus.out_dst_phys), 64'(0));
        chk("rst_old", 64'(bus.out_dst_old_phys), 64'(0));
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expected group
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst_in && bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 64'(bus.out_valid), 64'(0));
                end else begin
                    chk("lane_valid", 64'(bus.out_lane_valid), 64'(q[0].lv));
                    chk("src1", 64'(bus.out_src1_phys), 64'(q[0].s1));
                    chk("src2", 64'(bus.out_src2_phys), 64'(q[0].s2));
                    chk("flags_src", 64'(bus.out_flags_phys), 64'(q[0].fl));
                    chk("dst", 64'(bus.out_dst_phys), 64'(q[0].d));
                    chk("dst_old", 64'(bus.out_dst_old_phys), 64'(q[0].o));
                    chk("flag_dst", 64'(bus.out_flag_dst_phys), 64'(q[0].fd));
                    chk("flag_old", 64'(bus.out_flag_old_phys), 64'(q[0].fo));
                    chk("ckpt_id", 64'(bus.out_ckpt_id), 64'(0));
                    if (bus.out_ready || bus.flush_in) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        clear_inputs();
        rst_in = 1'b1;
        model_reset();
        do_reset();

        // ADD x1 <- x2, x3 then read x1 back
        nxt(); set_lane(0, 1, 1, 2, 3, 0, 0); set_frl(0, 40); step();
        nxt(); set_lane(0, 0, 0, 1, 1, 0, 0); step();
        // Intra-group bypass and last-writer-wins
        nxt(); set_lane(0, 1, 5, 0, 0, 1, 0); set_lane(1, 1, 5, 5, 2, 0, 1);
        set_frl(0, 50); set_frl(1, 51); set_frl(2, 90); step();
        nxt(); set_lane(0, 0, 0, 5, 5, 0, 1); step();
        // Free-list stall, then output backpressure holding data
        nxt(); set_lane(1, 1, 7, 0, 0, 0, 0); bus.frl_avail[1] = 1'b0; set_frl(1, 77); step();
        nxt(); set_lane(0, 1, 8, 1, 5, 1, 1); set_frl(0, 70); set_frl(2, 71); step();
        for (int k = 0; k < 3; k++) begin
            nxt(); bus.out_ready = 1'b0; set_lane(0, 1, 9, 8, 8, 0, 0); set_frl(0, 72); step();
        end
        // Commit then flush restores the committed mapping; fire in the flush cycle is blocked
        nxt(); set_lane(0, 1, 1, 0, 0, 0, 0); set_frl(0, 44); step();
        nxt(); bus.cm_valid[0] = 1'b1; bus.cm_arch[0 +: AW] = AW'(1); bus.cm_phys[0 +: PW] = PW'(44);
        set_lane(0, 1, 1, 0, 0, 0, 0); set_frl(0, 60); step();
        nxt(); bus.flush_in = 1'b1; set_lane(0, 1, 2, 1, 0, 0, 0); set_frl(0, 61); step();
        nxt(); set_lane(0, 0, 0, 1, 2, 0, 0); step();
        // Zero register: reads phys 0, writes pop nothing
        nxt(); set_lane(0, 1, 31, 31, 1, 0, 0); set_frl(0, 99); step();
        nxt(); set_lane(0, 0, 0, 31, 1, 0, 0); set_lane(1, 1, 31, 31, 31, 0, 0); step();

        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) do_reset();
            @(negedge clk);
            rand_stim();
            step();
        end

        for (int k = 0; k < 6; k++) begin
            nxt(); step();
        end
        chk("queue_drained", 64'(q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
